// File: rtl/imm_pack.sv
// Immediate packer: encodes ImmVal into instruction bits [31:7] per format, flags
// unrepresentable values, and queues results in a 2-entry FIFO. Optional macro: IMM_PACK_FAULTCNT_EN.
package imm_pack_pkg;
    localparam int unsigned IMM_W = 25;

    typedef struct packed {
        logic [IMM_W-1:0] imm;
        logic             fault;
    } entry_t;
endpackage

module imm_pack
    import imm_pack_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [2:0]       ImmSrc,
    input  logic [31:0]      ImmVal,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [IMM_W-1:0] OutImm,
    output logic             OutFault
`ifdef IMM_PACK_FAULTCNT_EN
    ,
    output logic [15:0]      FaultCnt
`endif
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;

    entry_t           mem [DEPTH];
    entry_t           new_entry;
    entry_t           head;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      ins;
    logic             fault;
    logic             push;
    logic             pop;
    logic             is_ok;
    logic             b_ok;
    logic             j_ok;

    // Sign-extension checks: upper bits must all replicate the immediate's sign bit
    assign is_ok = (&ImmVal[31:11]) | ~(|ImmVal[31:11]);
    assign b_ok  = ((&ImmVal[31:12]) | ~(|ImmVal[31:12])) & ~ImmVal[0];
    assign j_ok  = ((&ImmVal[31:20]) | ~(|ImmVal[31:20])) & ~ImmVal[0];

    always_comb begin
        ins   = '0;
        fault = 1'b0;
        case (ImmSrc)
            3'b000: begin
                ins[31:20] = ImmVal[11:0];
                fault      = ~is_ok;
            end
            3'b001: begin
                ins[31:25] = ImmVal[11:5];
                ins[11:7]  = ImmVal[4:0];
                fault      = ~is_ok;
            end
            3'b010: begin
                ins[31]    = ImmVal[12];
                ins[30:25] = ImmVal[10:5];
                ins[11:8]  = ImmVal[4:1];
                ins[7]     = ImmVal[11];
                fault      = ~b_ok;
            end
            3'b011: begin
                ins[31]    = ImmVal[20];
                ins[30:21] = ImmVal[10:1];
                ins[20]    = ImmVal[11];
                ins[19:12] = ImmVal[19:12];
                fault      = ~j_ok;
            end
            3'b100: begin
                ins[31:12] = ImmVal[31:12];
                fault      = |ImmVal[11:0];
            end
            default: begin
                ins   = '0;
                fault = 1'b1;
            end
        endcase
    end

    assign new_entry.imm   = ins[31:7];
    assign new_entry.fault = fault;

    assign InReady  = (count != CNT_W'(DEPTH));
    assign OutValid = (count != '0);
    assign push     = InValid & InReady;
    assign pop      = OutValid & OutReady;
    assign head     = mem[rd_ptr];
    assign OutImm   = OutValid ? head.imm : '0;
    assign OutFault = OutValid ? head.fault : 1'b0;

    // FIFO storage and pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef IMM_PACK_FAULTCNT_EN
    // Saturating count of accepted faulty requests
    always_ff @(posedge clk) begin
        if (rst) begin
            FaultCnt <= '0;
        end else if (push && fault && (FaultCnt != 16'hFFFF)) begin
            FaultCnt <= FaultCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_pack.sv
// Directed self-checking bench for imm_pack with hand-computed instruction words.
module tb_imm_pack;
    logic        clk = 1'b0;
    logic        rst;
    logic        InValid;
    logic        InReady;
    logic [2:0]  ImmSrc;
    logic [31:0] ImmVal;
    logic        OutValid;
    logic        OutReady;
    logic [24:0] OutImm;
    logic        OutFault;
`ifdef IMM_PACK_FAULTCNT_EN
    logic [15:0] FaultCnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    imm_pack dut (
        .clk      (clk),
        .rst      (rst),
        .InValid  (InValid),
        .InReady  (InReady),
        .ImmSrc   (ImmSrc),
        .ImmVal   (ImmVal),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutImm   (OutImm),
        .OutFault (OutFault)
`ifdef IMM_PACK_FAULTCNT_EN
        ,
        .FaultCnt (FaultCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] exp_ins, input logic exp_f);
        check({tag, ".valid"}, 32'(OutValid), 32'd1);
        check({tag, ".imm"}, {OutImm, 7'b0}, exp_ins);
        check({tag, ".fault"}, 32'(OutFault), 32'(exp_f));
    endtask

    // Accept one request into an empty FIFO, check it one cycle later, then drain it
    task automatic single(input string tag, input logic [2:0] src, input logic [31:0] val,
                          input logic [31:0] exp_ins, input logic exp_f);
        OutReady = 1'b0;
        InValid  = 1'b1;
        ImmSrc   = src;
        ImmVal   = val;
        step();
        InValid = 1'b0;
        check_head(tag, exp_ins, exp_f);
        OutReady = 1'b1;
        step();
        OutReady = 1'b0;
        check({tag, ".drained"}, 32'(OutValid), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        InValid  = 1'b0;
        ImmSrc   = 3'b000;
        ImmVal   = '0;
        OutReady = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        check("rst.valid", 32'(OutValid), 32'd0);
        check("rst.ready", 32'(InReady), 32'd1);
        check("rst.imm", 32'(OutImm), 32'd0);
        check("rst.fault", 32'(OutFault), 32'd0);

        single("i_neg",  3'b000, 32'hFFFFF800, 32'h80000000, 1'b0);
        single("i_ovf",  3'b000, 32'h00000800, 32'h80000000, 1'b1);
        single("s_pos",  3'b001, 32'h000007FF, 32'h7E000F80, 1'b0);
        single("b_ok",   3'b010, 32'h00000FFE, 32'h7E000F80, 1'b0);
        single("b_odd",  3'b010, 32'h00000003, 32'h00000100, 1'b1);
        single("j_ok",   3'b011, 32'h000FFFFE, 32'h7FFFF000, 1'b0);
        single("j_ovf",  3'b011, 32'h00100000, 32'h80000000, 1'b1);
        single("u_ok",   3'b100, 32'h12345000, 32'h12345000, 1'b0);
        single("u_low",  3'b100, 32'h12345001, 32'h12345000, 1'b1);
        single("illegal", 3'b111, 32'h12345000, 32'h00000000, 1'b1);

        // Backpressure: A, B fill the FIFO, C is held off until a slot frees
        OutReady = 1'b0;
        InValid = 1'b1; ImmSrc = 3'b000; ImmVal = 32'h00000005;
        step();
        check("bp.ready1", 32'(InReady), 32'd1);
        ImmSrc = 3'b100; ImmVal = 32'hABCDE000;
        step();
        check("bp.full", 32'(InReady), 32'd0);
        ImmSrc = 3'b001; ImmVal = 32'h00000003;
        step();
        check("bp.still_full", 32'(InReady), 32'd0);
        check_head("bp.hold_a", 32'h00500000, 1'b0);
        OutReady = 1'b1;
        step();
        check_head("bp.b", 32'hABCDE000, 1'b0);
        check("bp.slot", 32'(InReady), 32'd1);
        step();
        InValid = 1'b0;
        check_head("bp.c", 32'h00000180, 1'b0);
        step();
        check("bp.empty", 32'(OutValid), 32'd0);
        OutReady = 1'b0;

        // Reset with two entries queued and a request offered during reset
        InValid = 1'b1; ImmSrc = 3'b000; ImmVal = 32'h00000001;
        step();
        step();
        check("pre_rst.full", 32'(InReady), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        InValid = 1'b0;
        check("mid_rst.valid", 32'(OutValid), 32'd0);
        check("mid_rst.ready", 32'(InReady), 32'd1);
        check("mid_rst.imm", 32'(OutImm), 32'd0);
        single("fresh", 3'b100, 32'hFEDCB000, 32'hFEDCB000, 1'b0);

`ifdef IMM_PACK_FAULTCNT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("fc.reset", 32'(FaultCnt), 32'd0);
        OutReady = 1'b1;
        InValid  = 1'b1;
        ImmSrc   = 3'b111;
        repeat (3) step();
        check("fc.three", 32'(FaultCnt), 32'd3);
        repeat (65534) step();
        check("fc.sat", 32'(FaultCnt), 32'h0000FFFF);
        repeat (4) step();
        check("fc.hold", 32'(FaultCnt), 32'h0000FFFF);
        InValid  = 1'b0;
        OutReady = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/imm_pack.md
IMM_PACK -- requirements
Module: imm_pack

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 InValid  input  1  request present.
REQ-004 InReady  output  1  block can accept a request this cycle.
REQ-005 ImmSrc  input  3  format: 000 I, 001 S, 010 B, 011 J, 100 U, 101-111 illegal.
REQ-006 ImmVal  input  32  immediate value to be packed into instruction bits [31:7].
REQ-007 OutValid  output  1  OutImm/OutFault hold a result.
REQ-008 OutReady  input  1  consumer accepts the result this cycle.
REQ-009 OutImm  output  25  instruction bits [31:7]; OutImm[k-7] is instruction bit k.
REQ-010 OutFault  output  1  ImmVal was not representable in ImmSrc.
REQ-011 FaultCnt  output  16  saturating count of accepted faulty requests (only when IMM_PACK_FAULTCNT_EN is defined).

Function
REQ-012 Transfers: input on InValid&&InReady; output on OutValid&&OutReady.
REQ-013 Packing (v=ImmVal; all bits not listed are 0):
- I: [31:20]=v[11:0].
- S: [31:25]=v[11:5], [11:7]=v[4:0].
- B: [31]=v[12], [30:25]=v[10:5], [11:8]=v[4:1], [7]=v[11].
- J: [31]=v[20], [30:21]=v[10:1], [20]=v[11], [19:12]=v[19:12].
- U: [31:12]=v[31:12].
REQ-014 Fault conditions:
- I/S: v[31:11] not all equal.
- B: v[31:12] not all equal, or v[0]=1.
- J: v[31:20] not all equal, or v[0]=1.
- U: v[11:0]!=0.
- 101-111: always fault; OutImm=0.
REQ-015 A faulty request still produces OutImm packed per REQ-013 (except illegal ImmSrc) with OutFault=1; it is never dropped.
REQ-016 Packing and fault checking are combinational on the input; the results are stored in a 2-entry FIFO.
REQ-017 InReady=1 iff the FIFO holds fewer than 2 entries; InReady is a function of registered state only.
REQ-018 OutValid=1 iff the FIFO is non-empty; OutImm/OutFault show the head entry.
REQ-019 Latency: a request accepted at edge N into an empty FIFO gives OutValid=1 from edge N+1 onward.
REQ-020 Push and pop in the same cycle with 1 entry: occupancy stays 1, new entry becomes head.
REQ-021 Full (2 entries): InReady=0; a pop frees a slot visible from the next cycle.
REQ-022 Results are delivered strictly in acceptance order.
REQ-023 With OutValid=1 and OutReady=0, OutImm/OutFault remain stable.
REQ-024 FIFO read/write pointers wrap modulo 2.

Reset
REQ-025 While rst=1 at an edge: FIFO emptied, OutValid=0, OutImm=0, OutFault=0, FaultCnt=0; InReady=1 from the first cycle after reset.
REQ-026 Reset mid-operation discards all queued entries; InValid during reset is ignored.

Configuration
REQ-027 Macro IMM_PACK_FAULTCNT_EN.
- Defined: FaultCnt port exists; it increments by 1 on each accepted request with a fault and saturates at 0xFFFF.
- Not defined: FaultCnt port and counter are absent; all other behaviour is identical.

Verification
REQ-028 I-type, ImmVal=0xFFFFF800 -> OutImm[31:20]=0x800, rest 0, OutFault=0, OutValid one cycle after accept.
REQ-029 B-type:
- ImmVal=0x00000FFE -> [31]=0, [30:25]=0x3F, [11:8]=0xF, [7]=1, OutFault=0.
- ImmVal=0x00000003 -> OutFault=1.
REQ-030 U-type:
- ImmVal=0x12345000 -> OutImm[31:12]=0x12345, OutFault=0.
- ImmVal=0x12345001 -> OutFault=1.
- ImmSrc=111 -> OutImm=0, OutFault=1.
REQ-031 Backpressure: OutReady=0, offer 3 requests A,B,C -> InReady=0 after 2 accepts; then OutReady=1 -> A,B,C emerge in order with no loss or duplication.
REQ-032 Reset with 2 entries queued -> next cycle OutValid=0, InReady=1; a fresh request emerges alone.
REQ-033 With the macro defined, 65537 faulty accepts -> FaultCnt=0xFFFF and holds.
